// File: rtl/led_flash_driver_pkg.sv
// Shared state encoding and timing defaults for the button/LED chain.
// The timing defaults are also used by the button input chain.
package led_flash_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } flash_state_e;

    localparam int unsigned DEF_ON_CYCLES  = 5_000_000;  // 100 ms at 50 MHz
    localparam int unsigned DEF_OFF_CYCLES = 5_000_000;
    localparam int unsigned DEF_SIM_ON     = 4;
    localparam int unsigned DEF_SIM_OFF    = 3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Counter width able to reach n-1. Never returns less than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return ($clog2(n) > 0) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_flash_driver_timer.sv
// Interval timer: free-running counter with sync restart and a terminal-count flag.
module interval_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         restart,
    input  logic         run,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (restart) begin
            count_d = '0;
        end else if (run) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == term);

endmodule

// File: rtl/led_flash_driver.sv
// Turns one-cycle event pulses into LED flashes of T_ON on / T_OFF off,
// queueing pulses that arrive mid-flash in a saturating pending counter.
module led_flash_driver
    import led_flash_driver_pkg::*;
#(
    parameter bit          sim        = 1'b0,
    parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
    parameter int unsigned OFF_CYCLES = DEF_OFF_CYCLES,
    parameter int unsigned SIM_ON     = DEF_SIM_ON,
    parameter int unsigned SIM_OFF    = DEF_SIM_OFF,
    parameter int unsigned PEND_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pulse_in,
    input  logic              clear,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int unsigned T_ON  = sim ? SIM_ON  : ON_CYCLES;
    localparam int unsigned T_OFF = sim ? SIM_OFF : OFF_CYCLES;
    localparam int unsigned CNT_W = cnt_width(max_u(T_ON, T_OFF));

    flash_state_e      state_q, state_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              led_q, led_d;
    logic              busy_q, busy_d;

    logic              req, start, restart, run, tc;
    logic [CNT_W-1:0]  term;

    assign term = (state_q == ST_ON) ? CNT_W'(T_ON - 1) : CNT_W'(T_OFF - 1);
    assign req  = (pend_q != '0) || pulse_in;

    interval_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (reset),
        .restart (restart),
        .run     (run),
        .term    (term),
        .tc      (tc)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        start   = 1'b0;
        restart = 1'b0;
        run     = 1'b0;

        unique case (state_q)
            ST_IDLE: start = req;
            ST_ON: begin
                run = 1'b1;
                if (tc) begin
                    state_d = ST_OFF;
                    restart = 1'b1;
                end
            end
            ST_OFF: begin
                run = 1'b1;
                if (tc) begin
                    restart = 1'b1;
                    if (req) start = 1'b1;
                    else     state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A start consumes one queued event; a coincident new pulse replaces it.
        if (start) begin
            state_d = ST_ON;
            restart = 1'b1;
            if (!pulse_in) pend_d = pend_q - PEND_W'(1);
        end else if (pulse_in) begin
            if (pend_q == '1) ovf_d  = 1'b1;
            else              pend_d = pend_q + PEND_W'(1);
        end

        if (clear) begin
            state_d = ST_IDLE;
            pend_d  = '0;
            ovf_d   = 1'b0;
            restart = 1'b1;
            run     = 1'b0;
        end

        led_d  = (state_d == ST_ON);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    assign led      = led_q;
    assign busy     = busy_q;
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_led_flash_driver.sv
// Randomized/directed bench for led_flash_driver against a remaining-time flash model.
module tb_led_flash_driver;

    localparam int unsigned T_ON   = 4;
    localparam int unsigned T_OFF  = 3;
    localparam int unsigned PEND_W = 2;
    localparam int          PMAX   = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              pulse_in = 1'b0;
    logic              clear = 1'b0;
    logic              led, busy, overflow;
    logic [PEND_W-1:0] pending;

    int checks = 0;
    int failures = 0;

    // Model: cycles left in the current flash (0 = idle), queue depth, sticky loss flag.
    int m_rem = 0;
    int m_pend = 0;
    bit m_ovf = 1'b0;

    led_flash_driver #(
        .sim     (1'b1),
        .SIM_ON  (T_ON),
        .SIM_OFF (T_OFF),
        .PEND_W  (PEND_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pulse_in (pulse_in),
        .clear    (clear),
        .led      (led),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] exp_vec();
        logic m_led, m_busy;
        logic [PEND_W-1:0] p;
        m_led  = (m_rem > int'(T_OFF));
        m_busy = (m_rem > 0);
        p      = PEND_W'(m_pend);
        return {m_led, m_busy, p, m_ovf};
    endfunction

    task automatic model_edge(input bit p, input bit c);
        if (c) begin
            m_rem = 0; m_pend = 0; m_ovf = 1'b0;
        end else if (m_rem <= 1 && (m_pend > 0 || p)) begin
            m_rem  = T_ON + T_OFF;
            m_pend = m_pend + (p ? 1 : 0) - 1;
        end else begin
            if (m_rem > 0) m_rem--;
            if (p) begin
                if (m_pend == PMAX) m_ovf = 1'b1;
                else                m_pend++;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle for sampling.
    task automatic step(input bit p, input bit c);
        @(negedge clk);
        pulse_in = p;
        clear    = c;
        @(posedge clk);
        model_edge(p, c);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; pulse_in = 1'b0; clear = 1'b0;
        m_rem = 0; m_pend = 0; m_ovf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        @(negedge clk);
        pulse_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({led, busy, pending, overflow} !== 5'b0) begin
            failures++;
            $display("FAIL reset_async got=%b exp=%b", {led, busy, pending, overflow}, 5'b0);
        end
        m_rem = 0; m_pend = 0; m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({led, busy, pending, overflow} !== 5'b0) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=%b", {led, busy, pending, overflow}, 5'b0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        int led_cycles = 0;
        do_reset();
        for (int cyc = 1; cyc <= 20; cyc++) begin
            step(cyc == 10, 1'b0);
            checks++;
            if ({led, busy, pending, overflow} !== exp_vec()) begin
                failures++;
                $display("FAIL single cyc=%0d got=%b exp=%b", cyc, {led, busy, pending, overflow}, exp_vec());
            end
            if (cyc == 10) begin
                checks++;
                if (led !== 1'b1) begin
                    failures++;
                    $display("FAIL single_latency got=%b exp=1", led);
                end
            end
            if (led === 1'b1) led_cycles++;
        end
        checks++;
        if (led_cycles != int'(T_ON)) begin
            failures++;
            $display("FAIL single_on_len got=%0d exp=%0d", led_cycles, T_ON);
        end
    endtask

    task automatic test_burst();
        do_reset();
        for (int cyc = 1; cyc <= 34; cyc++) begin
            step(cyc >= 10 && cyc <= 12, 1'b0);
            checks++;
            if ({led, busy, pending, overflow} !== exp_vec()) begin
                failures++;
                $display("FAIL burst cyc=%0d got=%b exp=%b", cyc, {led, busy, pending, overflow}, exp_vec());
            end
        end
    endtask

    task automatic test_overflow();
        int flashes = 0;
        logic prev_led = 1'b0;
        do_reset();
        for (int cyc = 1; cyc <= 50; cyc++) begin
            step(cyc >= 10 && cyc <= 15, 1'b0);
            checks++;
            if ({led, busy, pending, overflow} !== exp_vec()) begin
                failures++;
                $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, {led, busy, pending, overflow}, exp_vec());
            end
            if (led === 1'b1 && prev_led === 1'b0) flashes++;
            prev_led = led;
        end
        checks++;
        if (flashes != PMAX + 1 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_total flashes=%0d ovf=%b exp flashes=%0d ovf=1", flashes, overflow, PMAX + 1);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int cyc = 1; cyc <= 28; cyc++) begin
            step(cyc == 10 || cyc == 17, 1'b0);
            checks++;
            if ({led, busy, pending, overflow} !== exp_vec()) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, {led, busy, pending, overflow}, exp_vec());
            end
            if (cyc == 17) begin
                checks++;
                if (led !== 1'b1 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL back_to_back_nogap led=%b busy=%b exp led=1 busy=1", led, busy);
                end
            end
        end
    endtask

    task automatic test_clear();
        do_reset();
        for (int cyc = 1; cyc <= 30; cyc++) begin
            step(cyc >= 9 && cyc <= 12 || cyc == 16, cyc == 12);
            checks++;
            if ({led, busy, pending, overflow} !== exp_vec()) begin
                failures++;
                $display("FAIL clear cyc=%0d got=%b exp=%b", cyc, {led, busy, pending, overflow}, exp_vec());
            end
            if (cyc == 12) begin
                checks++;
                if ({led, busy, pending, overflow} !== 5'b0) begin
                    failures++;
                    $display("FAIL clear_flush got=%b exp=%b", {led, busy, pending, overflow}, 5'b0);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            step($urandom_range(99) < 40, $urandom_range(99) < 3);
            checks++;
            if ({led, busy, pending, overflow} !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {led, busy, pending, overflow}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_back_to_back();
        test_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_flash_driver.md
Name: led_flash_driver

Overview:
- Output-side counterpart of the button input chain. The input chain turns a slow, bouncy human press into a one-cycle event pulse; this block turns one-cycle event pulses back into visible, human-length LED flashes.
- Each accepted pulse produces exactly one flash: LED on for T_ON cycles, then off for T_OFF cycles.
- Pulses arriving during a flash are queued in a saturating pending counter and replayed in order.
- Sits between any event source (e.g. a button chain output pulse) and a board LED pin.

Parameters:
- sim, 1'b0, selects simulation timing (1) or board timing (0).
- ON_CYCLES, 5_000_000, LED-on length in board mode (100 ms at 50 MHz).
- OFF_CYCLES, 5_000_000, LED-off gap in board mode.
- SIM_ON, 4, LED-on length when sim=1.
- SIM_OFF, 3, LED-off gap when sim=1.
- PEND_W, 4, pending counter width; maximum queued count is 2^PEND_W-1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- pulse_in  input  1  one-cycle event request; each high cycle counts as one event.
- clear  input  1  synchronous flush; abort current flash and drop the queue.
- led  output  1  registered LED drive.
- busy  output  1  high whenever state is not IDLE.
- pending  output  PEND_W  number of events queued but not yet started.
- overflow  output  1  sticky flag: an event was lost because the queue was saturated.

Behaviour:
- Effective timing: T_ON = sim ? SIM_ON : ON_CYCLES; T_OFF = sim ? SIM_OFF : OFF_CYCLES. Both must be ≥ 1.
- Interval counter width = clog2(max(T_ON, T_OFF)).
- Reset (asynchronous): state=IDLE, interval counter=0, led=0, busy=0, pending=0, overflow=0.
- Priority order: reset > clear > normal operation.
- clear=1: next edge gives state=IDLE, led=0, pending=0, overflow=0, counter=0. A pulse_in in the same cycle is ignored.
- "req" = (pending != 0) || pulse_in.
- Start action: state <= ON, counter <= 0, pending <= pending + pulse_in - 1. A simultaneous new pulse and consume therefore leaves pending unchanged.
- IDLE: if req, perform the start action; else hold.
- ON: led=1; counter increments each cycle. At counter == T_ON-1: state <= OFF, counter <= 0.
- OFF: led=0; counter increments each cycle. At counter == T_OFF-1:
  - if req, perform the start action (straight back to ON, no IDLE cycle);
  - else go to IDLE.
- Outside a start action, pulse_in increments pending.
  - If pending == 2^PEND_W-1, pending holds and overflow is set to 1.
  - overflow stays set until reset or clear.
- led and busy are registered (decoded from next state). A pulse sampled at edge n gives led=1 from the cycle after edge n.
- Latency: exactly 1 cycle from pulse_in (when IDLE) to led high.
- Flash period when back-to-back: T_ON + T_OFF cycles. LED-on windows never merge.
- pending never wraps or underflows.

Decomposition:
- Shared header: state encoding localparams (IDLE=2'd0, ON=2'd1, OFF=2'd2) and board/sim timing defaults, reused by the button chain.
- One natural sub-module, interval_timer: counter with sync restart and a terminal-count flag, parameterised by width.
- FSM and pending counter live in the top module.

Test Plan (sim=1, SIM_ON=4, SIM_OFF=3, PEND_W=2):
1. Assert reset mid-run, hold 2 cycles -> led=0, busy=0, pending=0, overflow=0 immediately (asynchronous), before any clk edge.
2. Single pulse_in at cycle 10 -> led=1 cycles 11–14, led=0 cycles 15–17, busy=1 cycles 11–17, busy=0 from cycle 18, pending stays 0.
3. pulse_in at cycles 10, 11, 12 -> pending reaches 2 at cycle 13; flashes on 11–14, 18–21, 25–28; no IDLE cycle between flashes; busy=0 from cycle 32.
4. pulse_in held for 6 consecutive cycles from cycle 10 -> pending 1, 2, 3, 3, 3; overflow=1 from cycle 15; exactly 4 flashes total; overflow stays 1 afterwards.
5. Single flash, plus pulse_in on the last OFF cycle (cycle 17) -> led=1 at cycle 18 with no IDLE gap; pending stays 0.
6. clear at cycle 12 with pending=2 -> led=0, busy=0, pending=0, overflow=0 from cycle 13. A pulse_in also at cycle 12 is ignored; a later pulse flashes normally.
